// File: rtl/ibus_ctrl.sv
// ---------------------------------------------------------------------------
// ibus_ctrl
//
// Instruction-bus controller sitting between the CPU fetch port and the
// instruction-side slaves (RAM and a synchronous boot ROM). The fetch address
// is decoded into three regions:
//    - RAM      : master_address[31:RAM_AW] == 0
//    - boot ROM : master_address[31:20] == ROM_BASE
//    - anything else is unmapped
// RAM accesses pass straight through combinationally. ROM reads are stretched
// by ROM_WAIT wait states. Writes to ROM and any access to unmapped space
// complete immediately and raise a one-cycle bus_err pulse in the following
// cycle.
//
// Optional feature (compile-time macro IBUS_TIMEOUT_EN):
//    When defined, a stall watchdog counts consecutive RAM stall cycles and
//    aborts the access once TIMEOUT stall cycles have been seen, so the master
//    never stalls longer than TIMEOUT cycles on a RAM access. When undefined,
//    RAM stalls pass through for as long as the RAM holds them.
//
// Parameters:
//    RAM_AW   : RAM address width
//    ROM_AW   : boot ROM address width
//    ROM_BASE : value of master_address[31:20] that selects the ROM
//    ROM_WAIT : ROM wait states (0..15), 0 means combinational ROM
//    TIMEOUT  : max consecutive RAM stall cycles (1..65535), watchdog only
//
// Ports:
//    clk                clock, all state updates on the rising edge
//    rst_n              synchronous active-low reset
//    master_address     fetch address, held while master_stall=1
//    master_byteenable  byte enables
//    master_read        read strobe, held while stalled
//    master_write       write strobe, held while stalled
//    master_wrdata      write data
//    master_rddata      read data, valid when master_stall=0 and master_read=1
//    master_stall       hold request
//    bus_err            registered one-cycle error pulse
//    bootrom_address    ROM address (low ROM_AW address bits)
//    bootrom_data_o     ROM read data
//    ram_address        RAM address (low RAM_AW address bits)
//    ram_data_i         RAM write data
//    ram_data_enable    RAM byte enables
//    ram_data_o         RAM read data
//    ram_rd             RAM read strobe
//    ram_wr             RAM write strobe
//    ram_stall          RAM not ready
// ---------------------------------------------------------------------------
module ibus_ctrl #(
   parameter int unsigned RAM_AW   = 24,
   parameter int unsigned ROM_AW   = 13,
   parameter logic [11:0] ROM_BASE = 12'h1fc,
   parameter int unsigned ROM_WAIT = 1,
   parameter int unsigned TIMEOUT  = 255
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [31:0]       master_address,
   input  logic [3:0]        master_byteenable,
   input  logic              master_read,
   input  logic              master_write,
   input  logic [31:0]       master_wrdata,
   output logic [31:0]       master_rddata,
   output logic              master_stall,
   output logic              bus_err,
   output logic [ROM_AW-1:0] bootrom_address,
   input  logic [31:0]       bootrom_data_o,
   output logic [RAM_AW-1:0] ram_address,
   output logic [31:0]       ram_data_i,
   output logic [3:0]        ram_data_enable,
   input  logic [31:0]       ram_data_o,
   output logic              ram_rd,
   output logic              ram_wr,
   input  logic              ram_stall
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ROM_WAIT,
      S_RAM_ACC,
      S_ABORT
   } stateT;

   stateT       r_state;
   logic [3:0]  r_wcnt;
   logic        r_busErr;

   logic        w_ramSel;
   logic        w_romSel;
   logic        w_req;
   logic        w_ramAcc;
   logic        w_romRead;
   logic        w_romWrite;
   logic        w_unmapped;

`ifdef IBUS_TIMEOUT_EN
   logic [15:0] r_scnt;
   logic [15:0] w_scntCur;
`endif

   // Reject out-of-range configurations at elaboration time rather than
   // letting the 4-bit and 16-bit counters silently wrap.
   if (ROM_WAIT > 15) begin : g_badRomWait
      $error("ibus_ctrl: ROM_WAIT must be in 0..15");
   end
   if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_badTimeout
      $error("ibus_ctrl: TIMEOUT must be in 1..65535");
   end

   // Slave-side address, data and byte-enable buses are plain slices of the
   // master request; only the strobes need qualifying.
   assign bootrom_address = master_address[ROM_AW-1:0];
   assign ram_address     = master_address[RAM_AW-1:0];
   assign ram_data_i      = master_wrdata;
   assign ram_data_enable = master_byteenable;
   assign bus_err         = r_busErr;

   // Address decode. RAM wins if a strange parameter set ever makes the two
   // windows overlap, so at most one region is selected at a time.
   assign w_ramSel   = (master_address[31:RAM_AW] == '0);
   assign w_romSel   = (master_address[31:20] == ROM_BASE) && !w_ramSel;
   assign w_req      = master_read || master_write;
   assign w_ramAcc   = w_ramSel && w_req;
   assign w_romRead  = w_romSel && master_read && !master_write;
   assign w_romWrite = w_romSel && master_write;
   assign w_unmapped = !w_ramSel && !w_romSel && w_req;

`ifdef IBUS_TIMEOUT_EN
   // Stall cycles already spent on the current RAM access. A fresh access
   // launched from IDLE starts from zero, so the first stalled cycle counts.
   assign w_scntCur = (r_state == S_RAM_ACC) ? r_scnt : 16'd0;
`endif

   // Master-facing outputs are combinational so the RAM path has zero
   // latency. IDLE and RAM_ACC behave identically here: RAM_ACC only exists
   // so the watchdog knows a stall is in progress. Holding rst_n low kills
   // the strobes and the stall so nothing leaks out while reset is applied.
   always_comb begin
      master_rddata = 32'd0;
      master_stall  = 1'b0;
      ram_rd        = 1'b0;
      ram_wr        = 1'b0;
      if (rst_n) begin
         case (r_state)
            S_IDLE, S_RAM_ACC: begin
               if (w_ramAcc) begin
                  ram_rd       = master_read;
                  ram_wr       = master_write;
                  master_stall = ram_stall;
                  if (master_read && !ram_stall) begin
                     master_rddata = ram_data_o;
                  end
               end else if (w_romRead) begin
                  if (ROM_WAIT == 0) begin
                     master_rddata = bootrom_data_o;
                  end else begin
                     master_stall = 1'b1;
                  end
               end
            end
            S_ROM_WAIT: begin
               if (master_read) begin
                  if (r_wcnt != 4'd0) begin
                     master_stall = 1'b1;
                  end else begin
                     master_rddata = bootrom_data_o;
                  end
               end
            end
            S_ABORT: begin
               master_stall = 1'b0;
            end
            default: begin
               master_stall = 1'b0;
            end
         endcase
      end
   end

   // Control FSM. The ROM wait counter is loaded with ROM_WAIT-1 on the
   // request cycle, so the stall lasts ROM_WAIT cycles and the data arrives
   // in cycle ROM_WAIT. Errors are flagged one cycle after the faulting
   // access completes, which keeps bus_err a clean registered pulse.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state  <= S_IDLE;
         r_wcnt   <= 4'd0;
         r_busErr <= 1'b0;
`ifdef IBUS_TIMEOUT_EN
         r_scnt   <= 16'd0;
`endif
      end else begin
         r_busErr <= 1'b0;
         case (r_state)
            S_IDLE, S_RAM_ACC: begin
               r_state <= S_IDLE;
`ifdef IBUS_TIMEOUT_EN
               r_scnt  <= 16'd0;
`endif
               if (w_ramAcc) begin
                  if (ram_stall) begin
`ifdef IBUS_TIMEOUT_EN
                     if (w_scntCur == 16'(TIMEOUT - 1)) begin
                        r_state <= S_ABORT;
                     end else begin
                        r_state <= S_RAM_ACC;
                        r_scnt  <= w_scntCur + 16'd1;
                     end
`else
                     r_state <= S_RAM_ACC;
`endif
                  end
               end else if (w_romRead) begin
                  if (ROM_WAIT != 0) begin
                     r_state <= S_ROM_WAIT;
                     r_wcnt  <= 4'(ROM_WAIT - 1);
                  end
               end else if (w_romWrite || w_unmapped) begin
                  r_busErr <= 1'b1;
               end
            end
            S_ROM_WAIT: begin
               if (!master_read || r_wcnt == 4'd0) begin
                  r_state <= S_IDLE;
                  r_wcnt  <= 4'd0;
               end else begin
                  r_wcnt  <= r_wcnt - 4'd1;
               end
            end
            S_ABORT: begin
               r_state  <= S_IDLE;
               r_busErr <= 1'b1;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ibus_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ibus_ctrl
//
// Self-checking bench for ibus_ctrl. Each master access is predicted at the
// transaction level: the bench classifies the address into RAM / ROM /
// unmapped by plain arithmetic, then states what the master must see cycle
// by cycle (stall pattern, returned data, strobes, and the error pulse that
// follows). Built with the watchdog enabled, the prediction also caps RAM
// stalls at TIMEOUT cycles followed by one abort cycle.
// ---------------------------------------------------------------------------
module tb_ibus_ctrl;

   localparam int ROM_WAIT = 2;
   localparam int TIMEOUT  = 4;
`ifdef IBUS_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic        clk;
   logic        rst_n;
   logic [31:0] master_address;
   logic [3:0]  master_byteenable;
   logic        master_read;
   logic        master_write;
   logic [31:0] master_wrdata;
   logic [31:0] master_rddata;
   logic        master_stall;
   logic        bus_err;
   logic [12:0] bootrom_address;
   logic [31:0] bootrom_data_o;
   logic [23:0] ram_address;
   logic [31:0] ram_data_i;
   logic [3:0]  ram_data_enable;
   logic [31:0] ram_data_o;
   logic        ram_rd;
   logic        ram_wr;
   logic        ram_stall;

   int numCompared   = 0;
   int numMismatched = 0;
   bit expErrNext    = 1'b0;

   ibus_ctrl #(
      .RAM_AW   (24),
      .ROM_AW   (13),
      .ROM_BASE (12'h1fc),
      .ROM_WAIT (ROM_WAIT),
      .TIMEOUT  (TIMEOUT)
   ) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .master_address    (master_address),
      .master_byteenable (master_byteenable),
      .master_read       (master_read),
      .master_write      (master_write),
      .master_wrdata     (master_wrdata),
      .master_rddata     (master_rddata),
      .master_stall      (master_stall),
      .bus_err           (bus_err),
      .bootrom_address   (bootrom_address),
      .bootrom_data_o    (bootrom_data_o),
      .ram_address       (ram_address),
      .ram_data_i        (ram_data_i),
      .ram_data_enable   (ram_data_enable),
      .ram_data_o        (ram_data_o),
      .ram_rd            (ram_rd),
      .ram_wr            (ram_wr),
      .ram_stall         (ram_stall)
   );

   // Free-running 100 MHz clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Region of an address: 0 = RAM (below 16 MiB), 1 = boot ROM window at
   // 0x1FC00000..0x1FCFFFFF, 2 = unmapped.
   function automatic int regionOf(input logic [31:0] a);
      if (a < 32'h0100_0000) return 0;
      if ((a >> 20) == 32'h0000_01fc) return 1;
      return 2;
   endfunction

   // One comparison point: counts it and reports any disagreement.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      numCompared++;
      assert (observed === expected) else begin
         numMismatched++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   // Checks one bus cycle at the falling edge, then moves to just after the
   // next rising edge where the next cycle's inputs get driven. errAfter is
   // whether this cycle completes an access that must raise bus_err next.
   task automatic checkCycle(input string tag, input bit eStall,
                             input logic [31:0] eData, input bit eRd,
                             input bit eWr, input bit errAfter);
      @(negedge clk);
      checkOutput({tag, ".stall"},  32'(master_stall), 32'(eStall));
      checkOutput({tag, ".rddata"}, master_rddata, eData);
      checkOutput({tag, ".ram_rd"}, 32'(ram_rd), 32'(eRd));
      checkOutput({tag, ".ram_wr"}, 32'(ram_wr), 32'(eWr));
      checkOutput({tag, ".bus_err"}, 32'(bus_err), 32'(expErrNext));
      checkOutput({tag, ".ram_addr"}, 32'(ram_address), 32'(master_address[23:0]));
      checkOutput({tag, ".rom_addr"}, 32'(bootrom_address), 32'(master_address[12:0]));
      checkOutput({tag, ".ram_wdata"}, ram_data_i, master_wrdata);
      checkOutput({tag, ".ram_be"}, 32'(ram_data_enable), 32'(master_byteenable));
      expErrNext = errAfter;
      @(posedge clk);
      #1;
   endtask

   task automatic idleCycle(input string tag);
      master_read  = 1'b0;
      master_write = 1'b0;
      checkCycle(tag, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
   endtask

   // Issues one complete master access and checks every cycle of it.
   // nStall is how many cycles the RAM holds ram_stall before it is ready.
   task automatic applyStimulus(input string tag, input logic [31:0] addr,
                                input bit isWrite, input int nStall);
      int  region;
      int  stalled;
      bit  done;
      region            = regionOf(addr);
      master_address    = addr;
      master_read       = !isWrite;
      master_write      = isWrite;
      master_wrdata     = $urandom;
      master_byteenable = 4'($urandom);
      stalled           = 0;
      done              = 1'b0;
      if (region == 0) begin
         while (!done) begin
            ram_data_o = $urandom;
            ram_stall  = (stalled < nStall);
            if (TO_EN && stalled == TIMEOUT) begin
               checkCycle({tag, ".abort"}, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
               done = 1'b1;
            end else if (ram_stall) begin
               checkCycle({tag, ".ramStall"}, 1'b1, 32'd0, !isWrite, isWrite, 1'b0);
               stalled++;
            end else begin
               checkCycle({tag, ".ramDone"}, 1'b0, isWrite ? 32'd0 : ram_data_o,
                          !isWrite, isWrite, 1'b0);
               done = 1'b1;
            end
         end
      end else if (region == 1) begin
         ram_stall = 1'($urandom);
         if (isWrite) begin
            bootrom_data_o = $urandom;
            checkCycle({tag, ".romWrite"}, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
         end else begin
            for (int w = 0; w <= ROM_WAIT; w++) begin
               bootrom_data_o = $urandom;
               ram_stall      = 1'($urandom);
               if (w < ROM_WAIT) begin
                  checkCycle({tag, ".romWait"}, 1'b1, 32'd0, 1'b0, 1'b0, 1'b0);
               end else begin
                  checkCycle({tag, ".romData"}, 1'b0, bootrom_data_o, 1'b0, 1'b0, 1'b0);
               end
            end
         end
      end else begin
         ram_stall = 1'($urandom);
         checkCycle({tag, ".unmapped"}, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
      end
      ram_stall = 1'b0;
   endtask

   initial begin
      logic [31:0] addr;
      int          kind;
      rst_n             = 1'b0;
      master_address    = 32'd0;
      master_byteenable = 4'd0;
      master_read       = 1'b0;
      master_write      = 1'b0;
      master_wrdata     = 32'd0;
      bootrom_data_o    = 32'd0;
      ram_data_o        = 32'd0;
      ram_stall         = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst_n      = 1'b1;
      expErrNext = 1'b0;

      // Outputs straight out of reset.
      idleCycle("reset");

      // RAM fetch, ROM read, unmapped access with a one-cycle error pulse.
      applyStimulus("ramFetch", 32'h0000_0100, 1'b0, 0);
      applyStimulus("romRead", 32'h1FC0_0004, 1'b0, 0);
      applyStimulus("unmapRd", 32'h8000_0000, 1'b0, 0);
      idleCycle("errPulse");
      idleCycle("errGone");

      // ROM write is refused, then a RAM read carries straight on.
      applyStimulus("romWr", 32'h1FC0_0000, 1'b1, 0);
      applyStimulus("ramAfterErr", 32'h0000_0200, 1'b0, 0);

      // Back-to-back ROM reads each pay the full wait.
      applyStimulus("romB2b0", 32'h1FC0_0008, 1'b0, 0);
      applyStimulus("romB2b1", 32'h1FC0_000C, 1'b0, 0);

      // Short and long RAM stalls; the long one trips the watchdog if built.
      applyStimulus("ramStall2", 32'h0000_0400, 1'b0, 2);
      applyStimulus("ramWrStall", 32'h00AB_CDE0, 1'b1, 1);
      applyStimulus("ramLong", 32'h0000_0800, 1'b0, TIMEOUT + 2);
      idleCycle("afterLong");
      idleCycle("afterLong2");

      // Read withdrawn in the middle of the ROM wait.
      master_address = 32'h1FC0_0010;
      master_read    = 1'b1;
      checkCycle("withdraw.req", 1'b1, 32'd0, 1'b0, 1'b0, 1'b0);
      master_read    = 1'b0;
      checkCycle("withdraw.drop", 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
      idleCycle("withdraw.idle");

      // Reset asserted during the ROM wait, then a fresh full-length read.
      master_address = 32'h1FC0_0020;
      master_read    = 1'b1;
      checkCycle("rstRom.req", 1'b1, 32'd0, 1'b0, 1'b0, 1'b0);
      rst_n = 1'b0;
      @(negedge clk);
      checkOutput("rstRom.stall", 32'(master_stall), 32'd0);
      checkOutput("rstRom.ram_rd", 32'(ram_rd), 32'd0);
      @(posedge clk);
      #1;
      rst_n       = 1'b1;
      master_read = 1'b0;
      expErrNext  = 1'b0;
      idleCycle("rstRom.idle");
      applyStimulus("rstRom.fresh", 32'h1FC0_0024, 1'b0, 0);

      // Reset asserted while a RAM read is stalled.
      master_address = 32'h0000_0040;
      master_read    = 1'b1;
      ram_stall      = 1'b1;
      checkCycle("rstRam.req", 1'b1, 32'd0, 1'b1, 1'b0, 1'b0);
      rst_n = 1'b0;
      @(negedge clk);
      checkOutput("rstRam.stall", 32'(master_stall), 32'd0);
      checkOutput("rstRam.ram_rd", 32'(ram_rd), 32'd0);
      checkOutput("rstRam.ram_wr", 32'(ram_wr), 32'd0);
      @(posedge clk);
      #1;
      rst_n       = 1'b1;
      ram_stall   = 1'b0;
      master_read = 1'b0;
      expErrNext  = 1'b0;
      idleCycle("rstRam.idle");
      applyStimulus("rstRam.fresh", 32'h0000_0044, 1'b0, TIMEOUT + 1);

      // Random mix of regions, directions and RAM stall lengths.
      for (int n = 0; n < 60; n++) begin
         kind = $urandom_range(0, 2);
         if (kind == 0) begin
            addr = $urandom & 32'h00FF_FFFC;
         end else if (kind == 1) begin
            addr = 32'h1FC0_0000 | ($urandom & 32'h000F_FFFC);
         end else begin
            addr = 32'h8000_0000 | $urandom;
         end
         applyStimulus("rand", addr, 1'($urandom), $urandom_range(0, 6));
         if ($urandom_range(0, 3) == 0) begin
            idleCycle("randIdle");
         end
      end
      idleCycle("final");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
      $finish;
   end

endmodule
